// File: rtl/data_sram_like_slave_pkg.sv
// Shared bus widths, size encodings and response payload for the data-side SRAM-like bus.
package data_sram_like_slave_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef struct packed {
    logic              wr;
    logic [DATA_W-1:0] data;
  } resp_t;

  // Replace the byte lanes selected by strb with the matching lanes of new_w.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [STRB_W-1:0] strb);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < int'(STRB_W); i++) begin
      if (strb[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/data_sram_like_slave_resp_fifo.sv
// In-order response buffer: each entry counts its age down to zero, head pops when ready.
module data_sram_like_slave_resp_fifo
  import data_sram_like_slave_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned AGE_W = 1,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  resp_t            push_data_i,
  input  logic [AGE_W-1:0] push_age_i,
  input  logic             pop_i,
  output logic             head_ready_o,
  output resp_t            head_data_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  resp_t            ent_q [DEPTH];
  logic [AGE_W-1:0] age_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_q + CNT_W'(push_i) - CNT_W'(pop_i);
    end
  end

  // Stale slots may also count down; they are rewritten on push and never read while empty.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (age_q[i] != '0) age_q[i] <= age_q[i] - AGE_W'(1);
    end
    if (push_i) begin
      ent_q[wr_ptr_q] <= push_data_i;
      age_q[wr_ptr_q] <= push_age_i;
    end
  end

  assign head_ready_o = (count_q != '0) && (age_q[rd_ptr_q] == '0);
  assign head_data_o  = ent_q[rd_ptr_q];
  assign count_o      = count_q;

endmodule

// File: rtl/data_sram_like_slave.sv
// Data-side SRAM-like bus responder backed by a word-addressed RAM with fixed response latency.
module data_sram_like_slave
  import data_sram_like_slave_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2      = 10,
  parameter int unsigned LATENCY         = 2,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              data_sram_req,
  input  logic              data_sram_wr,
  input  logic [1:0]        data_sram_size,
  input  logic [STRB_W-1:0] data_sram_wstrb,
  input  logic [ADDR_W-1:0] data_sram_addr,
  input  logic [DATA_W-1:0] data_sram_wdata,
  input  logic              stall,
  output logic              data_sram_addr_ok,
  output logic              data_sram_data_ok,
  output logic [DATA_W-1:0] data_sram_rdata
);

  localparam int unsigned WORDS    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned AGE_W    = (LATENCY > 3) ? $clog2(LATENCY - 1) : 1;
  localparam bit          BYPASS   = (LATENCY <= 1);
  // The decision edge is one edge after the push edge, so entries start at LATENCY-2.
  localparam logic [AGE_W-1:0] PUSH_AGE = AGE_W'((LATENCY > 1) ? LATENCY - 2 : 0);

  logic [DATA_W-1:0]     ram_q [WORDS];
  logic [DEPTH_LOG2-1:0] word_idx;
  logic                  hs, push, head_ready;
  resp_t                 push_data, head;
  logic [CNT_W-1:0]      count;
  logic                  data_ok_d, data_ok_q;
  logic [DATA_W-1:0]     rdata_d, rdata_q;
  logic                  unused_bits;

  assign word_idx    = data_sram_addr[DEPTH_LOG2+1:2];
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0],
                         data_sram_addr[ADDR_W-1:DEPTH_LOG2+2]};

  assign data_sram_addr_ok = !stall && (32'(count) < MAX_OUTSTANDING);
  assign hs                = data_sram_req && data_sram_addr_ok;
  assign push              = hs && !BYPASS;
  assign push_data         = {data_sram_wr, ram_q[word_idx]};

  always_ff @(posedge clk) begin
    if (hs && data_sram_wr) begin
      ram_q[word_idx] <= merge_lanes(ram_q[word_idx], data_sram_wdata, data_sram_wstrb);
    end
  end

  data_sram_like_slave_resp_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .AGE_W (AGE_W),
    .CNT_W (CNT_W)
  ) u_resp_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_data_i  (push_data),
    .push_age_i   (PUSH_AGE),
    .pop_i        (head_ready),
    .head_ready_o (head_ready),
    .head_data_o  (head),
    .count_o      (count)
  );

  // With LATENCY==1 the answer is issued straight from the handshake edge.
  always_comb begin
    data_ok_d = 1'b0;
    rdata_d   = rdata_q;
    if (BYPASS) begin
      if (hs) begin
        data_ok_d = 1'b1;
        rdata_d   = data_sram_wr ? '0 : ram_q[word_idx];
      end
    end else if (head_ready) begin
      data_ok_d = 1'b1;
      rdata_d   = head.wr ? '0 : head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      data_ok_q <= data_ok_d;
      rdata_q   <= rdata_d;
    end
  end

  assign data_sram_data_ok = data_ok_q;
  assign data_sram_rdata   = rdata_q;

endmodule
